cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single common data bus (CDB) between the functional-unit writeback ports (ALU, MUL, DIV, load).
//  Each port has a one-entry holding slot. A round-robin scheduler picks one slot per cycle and drives a
//  registered cdb_t to the ROB, the reservation stations and the physical register file.
//  Guarantees at most one broadcast per cycle and starvation-free service.
// PARAMETERS
//  N_REQ   4   number of writeback requesters; index 0=ALU, 1=MUL, 2=DIV, 3=LSQ load
//  PTR_W   $clog2(N_REQ)   width of the round-robin pointer (derived; do not override)
// PORTS
//  clk             input   1              single clock, rising edge
//  rst             input   1              asynchronous, active-low reset
//  flush           input   1              branch_flush from ROB; discards all pending results
//  req_valid       input   N_REQ          requester i presents a result
//  req_packet      input   N_REQ x cdb_t  result payload per requester (cdb_valid field ignored)
//  req_ready       output  N_REQ          slot i can accept this cycle (combinational)
//  cdb             output  cdb_t          registered broadcast; cdb.cdb_valid qualifies all fields
//  cdb_grant       output  N_REQ          registered one-hot source of the current cdb (0 when idle)
//  contention_cnt  output  32             saturating count of cycles with >=2 slots occupied
// BEHAVIOUR
//  Reset (rst=0, async):
//   - slot_v all 0; cdb='0; cdb_grant=0; rr_ptr=0; contention_cnt=0.
//   - req_ready evaluates to all 1 once reset is released.
//  Accept:
//   - req_ready[i] = !flush && (!slot_v[i] || win[i]).
//   - req_valid[i] && req_ready[i] at edge => slot_pkt[i] <= req_packet[i], slot_v[i] <= 1.
//  Arbitrate (combinational):
//   - win = first set bit of slot_v, searching rr_ptr, rr_ptr+1, ... mod N_REQ. At most one bit set.
//  Broadcast (edge after the win):
//   - cdb <= slot_pkt[w] with cdb_valid=1; cdb_grant <= win.
//   - rr_ptr <= (w+1) mod N_REQ; slot_v[w] <= 0 unless refilled in the same cycle.
//   - No winner => cdb <= '0 (all fields zero, not x); cdb_grant <= 0; rr_ptr holds.
//  Latency:
//   - Handshake in cycle t, uncontended => cdb_valid in cycle t+2.
//   - Worst case with all ports busy => t+1+N_REQ.
//  Throughput:
//   - One result per cycle total.
//   - A port can sustain one result per cycle only while it is the sole occupied slot (grant-and-refill same edge).
//  Flush (synchronous, flush=1 at edge):
//   - All slot_v <= 0; cdb <= '0; cdb_grant <= 0.
//   - req_ready forced 0, so no handshake occurs in the flush cycle.
//   - rr_ptr holds; contention_cnt holds.
//  Flush has priority over accept and broadcast in the same cycle.
//  contention_cnt: +1 per cycle where popcount(slot_v) >= 2 and flush=0; saturates at 32'hFFFF_FFFF.
//  No payload inspection: rob_index uniqueness is the issuing units' responsibility.
//  Reset asserted mid-operation drops pending slots immediately (async); cdb goes invalid the same cycle.
// STRUCTURE
//  Package rv32i_types (existing):
//   - cdb_t stays there.
//   - Add localparam CDB_NUM_REQ=4 and CDB_SRC_ALU/MUL/DIV/LD index constants.
//  Sub-module rr_arbiter:
//   - Purely combinational: slot_v + rr_ptr in, one-hot win out.
//   - Rotate, priority-encode, rotate back. Parameterised by N_REQ.
//  Top level holds the slots, the output register, rr_ptr and the counter. All flops use async active-low reset.
// TESTING
//  1 Single req: ALU valid, rob_index=5, result=32'h1234 at cycle 0 -> cdb_valid=1, rob_index=5, result=32'h1234,
//    cdb_grant=4'b0001 in cycle 2; idle afterwards.
//  2 All four valid at cycle 0, rr_ptr=0 -> grants 0001,0010,0100,1000 in cycles 2..5; contention_cnt=3;
//    req_ready low on ports 1..3 until each is granted.
//  3 Fairness: ALU and MUL held valid continuously -> cdb_grant alternates 0001/0010 every cycle; neither skips a turn.
//  4 Flush: slots 0 and 2 full, flush=1 with req_valid[1]=1 -> next cycle cdb_valid=0, all slots empty,
//    port 1 not accepted (req_ready[1]=0 during flush).
//  5 Refill: MUL alone valid every cycle for 8 cycles -> 8 consecutive cdb_valid with cdb_grant=0010; req_ready[1] stays 1.
//  6 Async reset pulsed mid-burst (scenario 2, cycle 3) -> cdb_valid=0 without a clock edge; no further grants until new requests.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rv32i_types
//  Description : Shared RV32I out-of-order core types. Holds the common data
//                bus payload (cdb_t) and the CDB requester index constants
//                used by cdb_arbiter and the writeback-side functional units.
//  Revision    : 1.1 - CDB requester constants and cdb_stamp helper added
// ============================================================================
package rv32i_types;

    localparam int XLEN       = 32;
    localparam int ROB_IDX_W  = 6;   // 64-entry reorder buffer
    localparam int PREG_IDX_W = 7;   // 128 physical registers

    // One CDB broadcast. cdb_valid qualifies every other field.
    typedef struct packed {
        logic                  cdb_valid;
        logic [ROB_IDX_W-1:0]  rob_index;
        logic [PREG_IDX_W-1:0] pd;
        logic [XLEN-1:0]       result;
    } cdb_t;

    // Writeback requesters sharing the CDB, in slot-index order.
    localparam int CDB_NUM_REQ = 4;
    localparam int CDB_SRC_ALU = 0;
    localparam int CDB_SRC_MUL = 1;
    localparam int CDB_SRC_DIV = 2;
    localparam int CDB_SRC_LD  = 3;

    // Requesters do not drive cdb_valid meaningfully; the arbiter sets it
    // when the packet is actually placed on the bus.
    function automatic cdb_t cdb_stamp(input cdb_t pkt);
        cdb_t r;
        r           = pkt;
        r.cdb_valid = 1'b1;
        return r;
    endfunction

endpackage : rv32i_types
`default_nettype wire

// File: rtl/cdb_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin picker. Returns the first
//                occupied slot found when searching from rr_ptr upward,
//                wrapping modulo N_REQ. Output is one-hot or all zero.
//  Ports       : slot_v  [N_REQ-1:0] in   occupied-slot mask
//                rr_ptr  [PTR_W-1:0] in   highest-priority index (< N_REQ)
//                win     [N_REQ-1:0] out  one-hot winner, 0 when no slot set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] slot_v,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] win
);

    logic [2*N_REQ-1:0] w_dbl_req;
    logic [N_REQ-1:0]   w_rot_req;
    logic [N_REQ-1:0]   w_rot_win;
    logic [2*N_REQ-1:0] w_dbl_win;

    // Rotate right so that slot rr_ptr lands on bit 0. Shifting a doubled
    // copy gives the wrap-around without a modulo on a non-power-of-two N.
    assign w_dbl_req = {slot_v, slot_v} >> rr_ptr;
    assign w_rot_req = w_dbl_req[N_REQ-1:0];

    // x & -x isolates the lowest set bit: the fixed-priority pick.
    assign w_rot_win = w_rot_req & (~w_rot_req + N_REQ'(1));

    // Rotate back left by the same amount; the upper half of the doubled
    // vector holds the wrapped result.
    assign w_dbl_win = {w_rot_win, w_rot_win} << rr_ptr;
    assign win       = w_dbl_win[2*N_REQ-1:N_REQ];

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Shares the single common data bus between the writeback
//                ports (0=ALU, 1=MUL, 2=DIV, 3=load). Each port owns a
//                one-entry holding slot; a round-robin scheduler picks one
//                slot per cycle and drives a registered cdb_t to the ROB,
//                reservation stations and physical register file.
//  Ports       : clk             in   rising-edge clock
//                rst             in   asynchronous reset, active LOW
//                flush           in   branch flush, discards all pending work
//                req_valid[N]    in   requester i presents a result
//                req_packet[N]   in   payload per requester (cdb_valid ignored)
//                req_ready[N]    out  slot i accepts this cycle (combinational)
//                cdb             out  registered broadcast, cdb_valid qualifies
//                cdb_grant[N]    out  registered one-hot source, 0 when idle
//                contention_cnt  out  saturating count of cycles with >=2
//                                     slots occupied (flush cycles excluded)
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int N_REQ = CDB_NUM_REQ,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [N_REQ-1:0]       req_valid,
    input  cdb_t [N_REQ-1:0]       req_packet,
    output logic [N_REQ-1:0]       req_ready,
    output cdb_t                   cdb,
    output logic [N_REQ-1:0]       cdb_grant,
    output logic [31:0]            contention_cnt
);

    localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] r_slot_v;
    cdb_t             r_slot_pkt [N_REQ];
    logic [PTR_W-1:0] r_rr_ptr;
    cdb_t             r_cdb;
    logic [N_REQ-1:0] r_grant;
    logic [31:0]      r_cnt;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] w_win;
    logic             w_any_win;
    logic [PTR_W-1:0] w_win_idx;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [N_REQ-1:0] w_ready;
    logic [N_REQ-1:0] w_accept;
    logic             w_contended;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .slot_v (r_slot_v),
        .rr_ptr (r_rr_ptr),
        .win    (w_win)
    );

    assign w_any_win = |w_win;

    // One-hot to index. The arbiter guarantees at most one bit is set.
    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win[i]) begin
                w_win_idx = PTR_W'(i);
            end
        end
    end

    // Next pointer is the slot just after the winner, wrapping at N_REQ.
    assign w_ptr_nxt = (w_win_idx == PTR_W'(N_REQ - 1)) ? '0
                                                        : w_win_idx + PTR_W'(1);

    // A slot that is leaving this cycle can be refilled at the same edge;
    // that is what lets a lone requester stream one result per cycle.
    assign w_ready  = {N_REQ{~flush}} & (~r_slot_v | w_win);
    assign w_accept = req_valid & w_ready;

    // Two or more bits set <=> clearing the lowest set bit leaves a residue.
    assign w_contended = (r_slot_v & (r_slot_v - N_REQ'(1))) != '0;

    // ------------------------------------------------------------------
    // Holding slots
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_v <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_slot_pkt[i] <= '0;
            end
        end else if (flush) begin
            r_slot_v <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept[i]) begin
                    r_slot_v[i]   <= 1'b1;
                    r_slot_pkt[i] <= req_packet[i];
                end else if (w_win[i]) begin
                    r_slot_v[i]   <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Broadcast register and round-robin pointer
    // ------------------------------------------------------------------
    // Idle and flushed cycles drive an all-zero packet rather than holding
    // stale fields, so downstream never sees x or a previous result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cdb    <= '0;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else if (flush) begin
            r_cdb    <= '0;
            r_grant  <= '0;
        end else if (w_any_win) begin
            r_cdb    <= cdb_stamp(r_slot_pkt[w_win_idx]);
            r_grant  <= w_win;
            r_rr_ptr <= w_ptr_nxt;
        end else begin
            r_cdb    <= '0;
            r_grant  <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Contention statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!flush && w_contended && (r_cnt != C_CNT_MAX)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready      = w_ready;
    assign cdb            = r_cdb;
    assign cdb_grant      = r_grant;
    assign contention_cnt = r_cnt;

endmodule : cdb_arbiter
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Self-checking bench for cdb_arbiter. Each scenario pushes
//                the broadcasts it expects (relative cycle, grant, payload)
//                into a scoreboard queue and pops them as the bus produces
//                valid packets; idle cycles must show an all-zero bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    import rv32i_types::*;

    localparam int N = CDB_NUM_REQ;

    typedef struct {
        int           cyc;
        logic [N-1:0] grant;
        cdb_t         pkt;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [N-1:0] req_valid;
    cdb_t [N-1:0] req_packet;
    logic [N-1:0] req_ready;
    cdb_t         cdb;
    logic [N-1:0] cdb_grant;
    logic [31:0]  contention_cnt;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   edges  = 0;

    cdb_arbiter #(.N_REQ(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .req_valid      (req_valid),
        .req_packet     (req_packet),
        .req_ready      (req_ready),
        .cdb            (cdb),
        .cdb_grant      (cdb_grant),
        .contention_cnt (contention_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running edge count; cycle numbers inside a test are relative to it.
    always @(posedge clk) edges <= edges + 1;

    function automatic cdb_t mk(input int port, input int tag);
        cdb_t p;
        p           = '0;
        p.rob_index = ROB_IDX_W'(port * 16 + tag);
        p.pd        = PREG_IDX_W'(port * 8 + tag + 1);
        p.result    = 32'hC0DE_0000 + 32'(port * 256 + tag);
        return p;
    endfunction

    function automatic cdb_t on_bus(input cdb_t p);
        cdb_t q;
        q           = p;
        q.cdb_valid = 1'b1;
        return q;
    endfunction

    task automatic push_exp(input int cyc, input int port, input cdb_t p);
        exp_t e;
        e.cyc   = cyc;
        e.grant = N'(1) << port;
        e.pkt   = on_bus(p);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        flush      = 1'b0;
        req_valid  = '0;
        req_packet = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        flush      = 1'b0;
        req_valid  = '0;
        req_packet = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (cdb !== '0 || cdb_grant !== '0 || contention_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: cdb=%h grant=%b cnt=%0d, required all zero",
                     cdb, cdb_grant, contention_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1111) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b, required 1111", req_ready);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        exp_t e;
        cdb_t p;
        int   base;
        do_reset();
        @(negedge clk);
        base        = edges;
        p           = '0;
        p.rob_index = ROB_IDX_W'(5);
        p.pd        = PREG_IDX_W'(9);
        p.result    = 32'h1234;
        req_valid     = 4'b0001;
        req_packet[0] = p;
        push_exp(2, 0, p);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (cdb.cdb_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL single_spurious: grant=%b rob=%0d cycle %0d, required idle",
                             cdb_grant, cdb.rob_index, c);
                end else begin
                    e = sb.pop_front();
                    if (edges - base != e.cyc || cdb_grant !== e.grant || cdb !== e.pkt) begin
                        errors++;
                        $display("FAIL single_bcast: cycle=%0d grant=%b cdb=%h, required cycle=%0d grant=%b cdb=%h",
                                 edges - base, cdb_grant, cdb, e.cyc, e.grant, e.pkt);
                    end
                end
            end else if (cdb !== '0 || cdb_grant !== '0) begin
                errors++;
                $display("FAIL single_idle: cdb=%h grant=%b cycle %0d, required zero", cdb, cdb_grant, c);
            end
            if (c == 1) req_valid = '0;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL single_missing: %0d broadcasts outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_all_four();
        exp_t         e;
        int           base;
        logic [N-1:0] rdy_tbl [7];
        rdy_tbl = '{4'b1111, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
        do_reset();
        @(negedge clk);
        base = edges;
        for (int i = 0; i < N; i++) begin
            req_packet[i] = mk(i, 0);
            push_exp(2 + i, i, mk(i, 0));
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== rdy_tbl[0]) begin
            errors++;
            $display("FAIL all4_ready c0: req_ready=%b, required %b", req_ready, rdy_tbl[0]);
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (cdb.cdb_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL all4_spurious: grant=%b cycle %0d, required idle", cdb_grant, c);
                end else begin
                    e = sb.pop_front();
                    if (edges - base != e.cyc || cdb_grant !== e.grant || cdb !== e.pkt) begin
                        errors++;
                        $display("FAIL all4_bcast: cycle=%0d grant=%b cdb=%h, required cycle=%0d grant=%b cdb=%h",
                                 edges - base, cdb_grant, cdb, e.cyc, e.grant, e.pkt);
                    end
                end
            end else if (cdb !== '0 || cdb_grant !== '0) begin
                errors++;
                $display("FAIL all4_idle: cdb=%h grant=%b cycle %0d, required zero", cdb, cdb_grant, c);
            end
            if (c <= 6) begin
                checks++;
                if (req_ready !== rdy_tbl[c]) begin
                    errors++;
                    $display("FAIL all4_ready c%0d: req_ready=%b, required %b", c, req_ready, rdy_tbl[c]);
                end
            end
            if (c == 1) req_valid = '0;
        end
        checks++;
        if (contention_cnt !== 32'd3) begin
            errors++;
            $display("FAIL all4_contention: cnt=%0d, required 3", contention_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL all4_missing: %0d broadcasts outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    // ------------------------------------------------------------------
    // ALU and MUL held valid: each refills when granted, so the payload on
    // the bus in cycle k was offered in cycle max(k-3, 0).
    task automatic test_fairness();
        exp_t e;
        int   base;
        int   port;
        do_reset();
        @(negedge clk);
        base = edges;
        for (int k = 2; k <= 10; k++) begin
            port = (k % 2 == 0) ? 0 : 1;
            push_exp(k, port, mk(port, (k > 3) ? k - 3 : 0));
        end
        req_valid     = 4'b0011;
        req_packet[0] = mk(0, 0);
        req_packet[1] = mk(1, 0);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            checks++;
            if (cdb.cdb_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL fair_spurious: grant=%b cycle %0d, required idle", cdb_grant, c);
                end else begin
                    e = sb.pop_front();
                    if (edges - base != e.cyc || cdb_grant !== e.grant || cdb !== e.pkt) begin
                        errors++;
                        $display("FAIL fair_bcast: cycle=%0d grant=%b cdb=%h, required cycle=%0d grant=%b cdb=%h",
                                 edges - base, cdb_grant, cdb, e.cyc, e.grant, e.pkt);
                    end
                end
            end else if (cdb !== '0 || cdb_grant !== '0) begin
                errors++;
                $display("FAIL fair_idle: cdb=%h grant=%b cycle %0d, required zero", cdb, cdb_grant, c);
            end
            if (c <= 7) begin
                req_packet[0] = mk(0, c);
                req_packet[1] = mk(1, c);
            end else begin
                req_valid = '0;
            end
        end
        checks++;
        if (contention_cnt !== 32'd8) begin
            errors++;
            $display("FAIL fair_contention: cnt=%0d, required 8", contention_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL fair_missing: %0d broadcasts outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        exp_t e;
        int   base;
        do_reset();
        @(negedge clk);
        base          = edges;
        req_valid     = 4'b0101;
        req_packet[0] = mk(0, 0);
        req_packet[2] = mk(2, 0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (cdb.cdb_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL flush_spurious: grant=%b cycle %0d, required idle", cdb_grant, c);
                end else begin
                    e = sb.pop_front();
                    if (edges - base != e.cyc || cdb_grant !== e.grant || cdb !== e.pkt) begin
                        errors++;
                        $display("FAIL flush_bcast: cycle=%0d grant=%b cdb=%h, required cycle=%0d grant=%b cdb=%h",
                                 edges - base, cdb_grant, cdb, e.cyc, e.grant, e.pkt);
                    end
                end
            end else if (cdb !== '0 || cdb_grant !== '0) begin
                errors++;
                $display("FAIL flush_idle: cdb=%h grant=%b cycle %0d, required zero", cdb, cdb_grant, c);
            end
            case (c)
                1: begin
                    flush         = 1'b1;
                    req_valid     = 4'b0010;
                    req_packet[1] = mk(1, 1);
                    #1;
                    checks++;
                    if (req_ready !== 4'b0000) begin
                        errors++;
                        $display("FAIL flush_ready_low: req_ready=%b, required 0000", req_ready);
                    end
                end
                2: begin
                    flush     = 1'b0;
                    req_valid = '0;
                    #1;
                    checks++;
                    if (req_ready !== 4'b1111) begin
                        errors++;
                        $display("FAIL flush_slots_empty: req_ready=%b, required 1111", req_ready);
                    end
                end
                3: begin
                    checks++;
                    if (contention_cnt !== 32'd0) begin
                        errors++;
                        $display("FAIL flush_contention: cnt=%0d, required 0", contention_cnt);
                    end
                    // Pointer must still be 0 after the flush: ALU goes first.
                    req_valid     = 4'b0011;
                    req_packet[0] = mk(0, 3);
                    req_packet[1] = mk(1, 3);
                    push_exp(5, 0, mk(0, 3));
                    push_exp(6, 1, mk(1, 3));
                end
                4: req_valid = '0;
                default: ;
            endcase
        end
        checks++;
        if (contention_cnt !== 32'd1) begin
            errors++;
            $display("FAIL flush_contention_after: cnt=%0d, required 1", contention_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL flush_missing: %0d broadcasts outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_refill();
        exp_t e;
        int   base;
        do_reset();
        @(negedge clk);
        base = edges;
        for (int k = 2; k <= 9; k++) push_exp(k, 1, mk(1, k - 2));
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) begin
                @(negedge clk);
                checks++;
                if (cdb.cdb_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL refill_spurious: grant=%b cycle %0d, required idle", cdb_grant, c);
                    end else begin
                        e = sb.pop_front();
                        if (edges - base != e.cyc || cdb_grant !== e.grant || cdb !== e.pkt) begin
                            errors++;
                            $display("FAIL refill_bcast: cycle=%0d grant=%b cdb=%h, required cycle=%0d grant=%b cdb=%h",
                                     edges - base, cdb_grant, cdb, e.cyc, e.grant, e.pkt);
                        end
                    end
                end else if (cdb !== '0 || cdb_grant !== '0) begin
                    errors++;
                    $display("FAIL refill_idle: cdb=%h grant=%b cycle %0d, required zero", cdb, cdb_grant, c);
                end
            end
            if (c <= 7) begin
                req_valid     = 4'b0010;
                req_packet[1] = mk(1, c);
                #1;
                checks++;
                if (req_ready[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL refill_ready c%0d: req_ready[1]=%b, required 1", c, req_ready[1]);
                end
            end else begin
                req_valid = '0;
            end
        end
        checks++;
        if (contention_cnt !== 32'd0) begin
            errors++;
            $display("FAIL refill_contention: cnt=%0d, required 0", contention_cnt);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL refill_missing: %0d broadcasts outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        exp_t e;
        int   base;
        do_reset();
        @(negedge clk);
        base = edges;
        for (int i = 0; i < N; i++) req_packet[i] = mk(i, 0);
        req_valid = 4'b1111;
        push_exp(2, 0, mk(0, 0));
        push_exp(3, 1, mk(1, 0));
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            checks++;
            if (cdb.cdb_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL areset_spurious: grant=%b cycle %0d, required idle", cdb_grant, c);
                end else begin
                    e = sb.pop_front();
                    if (edges - base != e.cyc || cdb_grant !== e.grant || cdb !== e.pkt) begin
                        errors++;
                        $display("FAIL areset_bcast: cycle=%0d grant=%b cdb=%h, required cycle=%0d grant=%b cdb=%h",
                                 edges - base, cdb_grant, cdb, e.cyc, e.grant, e.pkt);
                    end
                end
            end else if (cdb !== '0 || cdb_grant !== '0) begin
                errors++;
                $display("FAIL areset_idle: cdb=%h grant=%b cycle %0d, required zero", cdb, cdb_grant, c);
            end
            case (c)
                1: req_valid = '0;
                3: begin
                    // Pulse reset between edges; outputs must drop at once.
                    #1 rst = 1'b0;
                    #1;
                    checks++;
                    if (cdb.cdb_valid !== 1'b0 || cdb_grant !== '0 || contention_cnt !== 32'd0) begin
                        errors++;
                        $display("FAIL areset_immediate: valid=%b grant=%b cnt=%0d, required 0/0000/0",
                                 cdb.cdb_valid, cdb_grant, contention_cnt);
                    end
                    #1 rst = 1'b1;
                end
                5: begin
                    req_valid     = 4'b0100;
                    req_packet[2] = mk(2, 5);
                    push_exp(7, 2, mk(2, 5));
                end
                6: req_valid = '0;
                default: ;
            endcase
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL areset_missing: %0d broadcasts outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst        = 1'b0;
        flush      = 1'b0;
        req_valid  = '0;
        req_packet = '0;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_flush();
        test_refill();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_cdb_arbiter
`default_nettype wire
